alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode-to-execute pipeline register directly upstream of the 12-op one-hot ALU.
//  Decodes a 32-bit MIPS instruction and selects operands A/B from regfile values,
//  shamt and immediate. Produces the one-hot ALUop and registers it all in a one-entry
//  valid/ready stage. Feeds the ALU's A, B and ALUop inputs, plus writeback tags.
// PARAMETERS
//  DATA_WIDTH  32  operand/PC width
//  OP_WIDTH    12  ALUop width, one-hot
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   upstream has an instruction
//  in_ready     out  1   stage can accept this cycle
//  in_inst      in   32  instruction word
//  in_pc        in   32  PC of instruction
//  in_rs_value  in   32  regfile read of rs
//  in_rt_value  in   32  regfile read of rt
//  flush        in   1   discard held entry and any same-cycle input
//  out_valid    out  1   registered entry valid
//  out_ready    in   1   ALU side consumes entry
//  out_alu_a    out  32  ALU operand A
//  out_alu_b    out  32  ALU operand B
//  out_alu_op   out  12  one-hot ALUop
//  out_dest     out  5   writeback register (0 if none)
//  out_wen      out  1   writeback enable
//  out_pc       out  32  PC of held instruction
//  out_illegal  out  1   unsupported encoding (alu_op = 0)
// BEHAVIOUR
//  - Reset: out_valid=0; all other outputs 0. Applies mid-transfer; held entry dropped.
//  - in_ready = !out_valid | out_ready (combinational; no bubble under full throughput).
//  - Load on in_valid & in_ready & !flush; latency 1 cycle inst->out.
//  - Drain: out_valid & out_ready with no load -> out_valid=0 next cycle.
//  - flush: out_valid=0 next cycle, regardless of in_valid/out_ready. Flush wins over load.
//  - Held outputs are stable while out_valid & !out_ready.
//  - ALUop bits: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 slt, 7 sltu,
//    8 sll, 9 srl, 10 sra, 11 lui. Exactly one bit set for legal ops.
//  - R-type (op 0x00), dest = rd, wen = (rd != 0):
//    - funct 21 addu / 23 subu / 24 and / 25 or / 26 xor / 27 nor / 2a slt / 2b sltu:
//      A = rs, B = rt.
//    - funct 00 sll / 02 srl / 03 sra: A = {27'b0, shamt}, B = rt.
//    - funct 04 sllv / 06 srlv / 07 srav: A = rs, B = rt. ALU shifts B by A[4:0].
//  - I-type, dest = rt, wen = (rt != 0), A = rs:
//    - sign-extended imm: 09 addiu->add, 0a slti->slt, 0b sltiu->sltu, 23 lw->add.
//    - zero-extended imm: 0c andi->and, 0d ori->or, 0e xori->xor.
//    - 0f lui->lui: A = 0, B = zero-extended imm.
//  - No writeback (dest = 0, wen = 0):
//    - 2b sw->add: A = rs, B = sign-extended imm.
//    - 04 beq / 05 bne->sub: A = rs, B = rt.
//  - Any other encoding: alu_op = 0, illegal = 1, wen = 0, A = B = 0. Still handshaked.
// STRUCTURE
//  - Shared header alu_defs.vh: ALUop bit indices, one-hot constants, opcode/funct localparams.
//    Included by both this block and the ALU.
//  - Sub-module alu_decoder: combinational inst->{alu_op, sel_a, sel_b, ext, dest, wen, illegal}.
//  - This block: operand muxes, valid/ready register, flush/reset.
// TESTING
//  - addiu $2,$1,-1 (0x2422FFFF), rs=5 -> next cycle A=5, B=FFFFFFFF, op=001, dest=2, wen=1.
//  - sll $3,$4,4 (0x00041900), rt=0x0000000F -> A=4, B=0000000F, op=100, dest=3.
//  - lui $5,0x1234 (0x3C051234) -> A=0, B=00001234, op=800.
//    ori $5,$5,0x8000, rs=1 -> B=00008000 (zero-extended), op=008.
//  - Backpressure: load addu, hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable.
//    out_ready=1 with in_valid=1 -> next entry loads, no bubble.
//  - flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; nothing loaded.
//    rst=1 mid-stall -> all outputs 0.
//  - Illegal inst 0xFC000000 -> out_valid=1, illegal=1, op=000, wen=0.
//    sw (0xAC220004) -> op=001, B=4, wen=0.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared decode definitions for the ALU issue stage: ALUop bit indices, opcode/funct
// encodings, operand-select enums and the decoder output bundle.
package alu_issue_stage_pkg;

  localparam int ALU_OP_W = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_NOR  = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SLT  = 6;
  localparam int ALU_SLTU = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {
    SEL_A_RS    = 2'd0,
    SEL_A_SHAMT = 2'd1,
    SEL_A_ZERO  = 2'd2
  } sel_a_e;

  typedef enum logic [1:0] {
    SEL_B_RT       = 2'd0,
    SEL_B_IMM_SEXT = 2'd1,
    SEL_B_IMM_ZEXT = 2'd2,
    SEL_B_ZERO     = 2'd3
  } sel_b_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    sel_a_e              sel_a;
    sel_b_e              sel_b;
    logic [4:0]          dest;
    logic                wen;
    logic                illegal;
  } dec_t;

  function automatic logic [ALU_OP_W-1:0] alu_onehot(input int idx);
    logic [ALU_OP_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational MIPS instruction decoder: ALUop, operand selects, writeback tag and
// illegal flag for the issue stage.
module alu_issue_stage_decoder
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [5:0] funct,
  output dec_t       dec
);

  logic [ALU_OP_W-1:0] op;
  sel_a_e              sel_a;
  sel_b_e              sel_b;
  logic [4:0]          dest;

  always_comb begin
    op    = '0;
    sel_a = SEL_A_RS;
    sel_b = SEL_B_RT;
    dest  = '0;
    case (opcode)
      OPC_RTYPE: begin
        dest = rd;
        case (funct)
          FN_ADDU: op = alu_onehot(ALU_ADD);
          FN_SUBU: op = alu_onehot(ALU_SUB);
          FN_AND:  op = alu_onehot(ALU_AND);
          FN_OR:   op = alu_onehot(ALU_OR);
          FN_XOR:  op = alu_onehot(ALU_XOR);
          FN_NOR:  op = alu_onehot(ALU_NOR);
          FN_SLT:  op = alu_onehot(ALU_SLT);
          FN_SLTU: op = alu_onehot(ALU_SLTU);
          FN_SLL:  begin op = alu_onehot(ALU_SLL); sel_a = SEL_A_SHAMT; end
          FN_SRL:  begin op = alu_onehot(ALU_SRL); sel_a = SEL_A_SHAMT; end
          FN_SRA:  begin op = alu_onehot(ALU_SRA); sel_a = SEL_A_SHAMT; end
          // Variable shifts: the ALU shifts B by A[4:0], so rs goes on A.
          FN_SLLV: op = alu_onehot(ALU_SLL);
          FN_SRLV: op = alu_onehot(ALU_SRL);
          FN_SRAV: op = alu_onehot(ALU_SRA);
          default: op = '0;
        endcase
      end
      OPC_ADDIU, OPC_LW: begin op = alu_onehot(ALU_ADD);  sel_b = SEL_B_IMM_SEXT; dest = rt; end
      OPC_SLTI:          begin op = alu_onehot(ALU_SLT);  sel_b = SEL_B_IMM_SEXT; dest = rt; end
      OPC_SLTIU:         begin op = alu_onehot(ALU_SLTU); sel_b = SEL_B_IMM_SEXT; dest = rt; end
      OPC_ANDI:          begin op = alu_onehot(ALU_AND);  sel_b = SEL_B_IMM_ZEXT; dest = rt; end
      OPC_ORI:           begin op = alu_onehot(ALU_OR);   sel_b = SEL_B_IMM_ZEXT; dest = rt; end
      OPC_XORI:          begin op = alu_onehot(ALU_XOR);  sel_b = SEL_B_IMM_ZEXT; dest = rt; end
      OPC_LUI: begin
        op    = alu_onehot(ALU_LUI);
        sel_a = SEL_A_ZERO;
        sel_b = SEL_B_IMM_ZEXT;
        dest  = rt;
      end
      OPC_SW:            begin op = alu_onehot(ALU_ADD); sel_b = SEL_B_IMM_SEXT; end
      OPC_BEQ, OPC_BNE:  op = alu_onehot(ALU_SUB);
      default:           op = '0;
    endcase

    dec.alu_op  = op;
    dec.illegal = (op == '0);
    if (dec.illegal) begin
      dec.sel_a = SEL_A_ZERO;
      dec.sel_b = SEL_B_ZERO;
      dec.dest  = '0;
      dec.wen   = 1'b0;
    end else begin
      dec.sel_a = sel_a;
      dec.sel_b = sel_b;
      dec.dest  = dest;
      dec.wen   = (dest != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register: decodes the instruction, muxes ALU operands and holds
// the result in a one-entry valid/ready stage with flush.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs_value,
  input  logic [DATA_WIDTH-1:0] in_rt_value,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_a,
  output logic [DATA_WIDTH-1:0] out_alu_b,
  output logic [OP_WIDTH-1:0]   out_alu_op,
  output logic [4:0]            out_dest,
  output logic                  out_wen,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
);

  dec_t                  dec;
  logic [15:0]           imm;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  load;
  // The rs index is not needed here: the regfile value arrives on in_rs_value.
  logic                  unused_rs_idx;

  logic                  valid_q,   valid_d;
  logic [DATA_WIDTH-1:0] alu_a_q,   alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q,   alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q,  alu_op_d;
  logic [4:0]            dest_q,    dest_d;
  logic                  wen_q,     wen_d;
  logic [DATA_WIDTH-1:0] pc_q,      pc_d;
  logic                  illegal_q, illegal_d;

  assign imm           = in_inst[15:0];
  assign shamt         = in_inst[10:6];
  assign unused_rs_idx = ^in_inst[25:21];

  alu_issue_stage_decoder u_decoder (
    .opcode (in_inst[31:26]),
    .rt     (in_inst[20:16]),
    .rd     (in_inst[15:11]),
    .funct  (in_inst[5:0]),
    .dec    (dec)
  );

  always_comb begin
    alu_a = '0;
    case (dec.sel_a)
      SEL_A_RS:    alu_a = in_rs_value;
      SEL_A_SHAMT: alu_a = {{(DATA_WIDTH-5){1'b0}}, shamt};
      default:     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (dec.sel_b)
      SEL_B_RT:       alu_b = in_rt_value;
      SEL_B_IMM_SEXT: alu_b = {{(DATA_WIDTH-16){imm[15]}}, imm};
      SEL_B_IMM_ZEXT: alu_b = {{(DATA_WIDTH-16){1'b0}}, imm};
      default:        alu_b = '0;
    endcase
  end

  // Stage boundary: accept whenever the slot is empty or is being drained this cycle.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d   = valid_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    dest_d    = dest_q;
    wen_d     = wen_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      alu_a_d   = alu_a;
      alu_b_d   = alu_b;
      alu_op_d  = dec.alu_op;
      dest_d    = dec.dest;
      wen_d     = dec.wen;
      pc_d      = in_pc;
      illegal_d = dec.illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      dest_q    <= '0;
      wen_q     <= 1'b0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      dest_q    <= dest_d;
      wen_q     <= wen_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_a   = alu_a_q;
  assign out_alu_b   = alu_b_q;
  assign out_alu_op  = alu_op_q;
  assign out_dest    = dest_q;
  assign out_wen     = wen_q;
  assign out_pc      = pc_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed
// operands, backpressure, flush and mid-stall reset.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] op;
    logic [4:0]  dest;
    logic        wen;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs_value;
  logic [31:0] in_rt_value;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [11:0] out_alu_op;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic [31:0] out_pc;
  logic        out_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t drop_e;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs_value (in_rs_value),
    .in_rt_value (in_rt_value),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_a   (out_alu_a),
    .out_alu_b   (out_alu_b),
    .out_alu_op  (out_alu_op),
    .out_dest    (out_dest),
    .out_wen     (out_wen),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [11:0] op,
                              input logic [4:0] dest, input logic wen, input logic ill,
                              input logic [31:0] pc);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.dest = dest; e.wen = wen; e.ill = ill; e.pc = pc;
    return e;
  endfunction

  // Monitor: every handshake on the output side pops one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output pc=%h expected=none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_alu_a",   out_alu_a,   mon_e.a);
        chk("out_alu_b",   out_alu_b,   mon_e.b);
        chk("out_alu_op",  {20'd0, out_alu_op}, {20'd0, mon_e.op});
        chk("out_dest",    {27'd0, out_dest},   {27'd0, mon_e.dest});
        chk("out_wen",     {31'd0, out_wen},    {31'd0, mon_e.wen});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
        chk("out_pc",      out_pc,      mon_e.pc);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the entry.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input exp_t e);
    bit accepted = 0;
    in_valid    = 1'b1;
    in_inst     = inst;
    in_pc       = pc;
    in_rs_value = rs;
    in_rt_value = rt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout inst=%h expected=accepted", inst);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_alu_a"},     out_alu_a, 32'd0);
    chk({tag, "_alu_b"},     out_alu_b, 32'd0);
    chk({tag, "_alu_op"},    {20'd0, out_alu_op}, 32'd0);
    chk({tag, "_dest"},      {27'd0, out_dest}, 32'd0);
    chk({tag, "_wen"},       {31'd0, out_wen}, 32'd0);
    chk({tag, "_pc"},        out_pc, 32'd0);
    chk({tag, "_illegal"},   {31'd0, out_illegal}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    in_rs_value = '0; in_rt_value = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Back-to-back directed vectors at full throughput.
    issue(32'h2422FFFF, 32'h100, 32'h5, 32'h0,  mk(32'h5, 32'hFFFFFFFF, 12'h001, 5'd2, 1, 0, 32'h100));
    issue(32'h00041900, 32'h104, 32'h99, 32'hF, mk(32'h4, 32'h0000000F, 12'h100, 5'd3, 1, 0, 32'h104));
    issue(32'h3C051234, 32'h108, 32'h77, 32'h0, mk(32'h0, 32'h00001234, 12'h800, 5'd5, 1, 0, 32'h108));
    issue(32'h34A58000, 32'h10C, 32'h1, 32'h0,  mk(32'h1, 32'h00008000, 12'h008, 5'd5, 1, 0, 32'h10C));
    issue(32'hAC220004, 32'h110, 32'h10, 32'h20, mk(32'h10, 32'h4, 12'h001, 5'd0, 0, 0, 32'h110));
    issue(32'hFC000000, 32'h114, 32'h10, 32'h20, mk(32'h0, 32'h0, 12'h000, 5'd0, 0, 1, 32'h114));
    issue(32'h10220003, 32'h118, 32'h10, 32'h20, mk(32'h10, 32'h20, 12'h002, 5'd0, 0, 0, 32'h118));
    issue(32'h00223823, 32'h11C, 32'h10, 32'h20, mk(32'h10, 32'h20, 12'h002, 5'd7, 1, 0, 32'h11C));
    issue(32'h00224007, 32'h120, 32'h3, 32'h80,  mk(32'h3, 32'h80, 12'h400, 5'd8, 1, 0, 32'h120));
    issue(32'h2823FFFE, 32'h124, 32'h10, 32'h20, mk(32'h10, 32'hFFFFFFFE, 12'h040, 5'd3, 1, 0, 32'h124));
    issue(32'h00200021, 32'h128, 32'h10, 32'h20, mk(32'h10, 32'h20, 12'h001, 5'd0, 0, 0, 32'h128));
    idle(2);

    // Backpressure: addu held for three cycles with the next instruction waiting.
    out_ready = 1'b0;
    issue(32'h00221821, 32'h200, 32'h7, 32'h8, mk(32'h7, 32'h8, 12'h001, 5'd3, 1, 0, 32'h200));
    in_valid = 1'b1; in_inst = 32'h00222026; in_pc = 32'h204;
    in_rs_value = 32'hF0F0; in_rt_value = 32'h0FF0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_alu_a",     out_alu_a, 32'h7);
      chk("bp_alu_b",     out_alu_b, 32'h8);
      chk("bp_pc",        out_pc, 32'h200);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(32'hF0F0, 32'h0FF0, 12'h020, 5'd4, 1, 0, 32'h204));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    idle(1);

    // Flush with a held entry and a waiting input.
    out_ready = 1'b0;
    issue(32'h00222827, 32'h300, 32'h1, 32'h2, mk(32'h1, 32'h2, 12'h010, 5'd5, 1, 0, 32'h300));
    in_valid = 1'b1; in_inst = 32'h2422FFFF; in_pc = 32'h304;
    flush = 1'b1;
    drop_e = exp_q.pop_back();
    @(negedge clk);
    chk("flush_pre_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Flush beats a load that would otherwise be accepted.
    in_valid = 1'b1; in_inst = 32'h3C051234; in_pc = 32'h308; flush = 1'b1;
    @(negedge clk);
    chk("flush_load_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_load_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset while stalled drops the held entry.
    out_ready = 1'b0;
    issue(32'h0022302B, 32'h400, 32'h1, 32'h2, mk(32'h1, 32'h2, 12'h080, 5'd6, 1, 0, 32'h400));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst_stall");
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    issue(32'h3022FFFF, 32'h500, 32'h12345678, 32'h0, mk(32'h12345678, 32'h0000FFFF, 12'h004, 5'd2, 1, 0, 32'h500));
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
